// File: rtl/pwm_tone_engine.sv
// Eight-note tone sequencer driving a phase accumulator, sine lookup and
// shadow-registered PWM stage; o_pwm carries the sine-modulated waveform.
module pwm_tone_engine #(
  parameter int unsigned NOTE_TICKS = 6_250_000,
  parameter logic [7:0]  PWM_TOP    = 8'd63
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_pwm,
  output logic        o_pwm_n,
  output logic        o_phase_msb,
  output logic        o_cycle_end,
  output logic [2:0]  o_note_index,
  output logic [31:0] o_phase
);

  localparam logic [31:0] TICK_LAST = 32'(NOTE_TICKS - 1);

  localparam logic [31:0] NOTE_DELTA [0:7] = '{
    32'd44947, 32'd50451, 32'd56630, 32'd59997,
    32'd67344, 32'd75591, 32'd84848, 32'd89894
  };

  // First quadrant of round(128*sin(2*pi*i/256)), i = 0..64; the other three
  // quadrants are mirrored/negated from it, matching the full 256-entry table.
  localparam logic [7:0] QSIN [0:64] = '{
    8'd0,   8'd3,   8'd6,   8'd9,   8'd13,  8'd16,  8'd19,  8'd22,
    8'd25,  8'd28,  8'd31,  8'd34,  8'd37,  8'd40,  8'd43,  8'd46,
    8'd49,  8'd52,  8'd55,  8'd58,  8'd60,  8'd63,  8'd66,  8'd68,
    8'd71,  8'd74,  8'd76,  8'd79,  8'd81,  8'd84,  8'd86,  8'd88,
    8'd91,  8'd93,  8'd95,  8'd97,  8'd99,  8'd101, 8'd103, 8'd105,
    8'd106, 8'd108, 8'd110, 8'd111, 8'd113, 8'd114, 8'd116, 8'd117,
    8'd118, 8'd119, 8'd121, 8'd122, 8'd122, 8'd123, 8'd124, 8'd125,
    8'd126, 8'd126, 8'd127, 8'd127, 8'd127, 8'd128, 8'd128, 8'd128,
    8'd128
  };

  logic [31:0] tick_cnt;
  logic [2:0]  note_idx;
  logic [31:0] delta_q;
  logic [31:0] phase;
  logic        top_sent;
  logic        top_valid;
  logic [7:0]  sin_idx;
  logic [6:0]  q_addr;
  logic [7:0]  q_val;
  logic [8:0]  sine_next;
  logic [8:0]  sine_q;
  logic [8:0]  compare;
  logic [7:0]  shadow_top;
  logic [8:0]  shadow_cmp;
  logic [7:0]  active_top;
  logic [8:0]  active_cmp;
  logic [7:0]  pwm_cnt;
  logic        period_end;
  logic        pwm_q;

  // Note sequencer
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      tick_cnt <= '0;
      note_idx <= '0;
      delta_q  <= NOTE_DELTA[0];
      top_sent <= 1'b0;
    end else begin
      top_sent <= 1'b1;
      delta_q  <= NOTE_DELTA[note_idx];
      if (tick_cnt == TICK_LAST) begin
        tick_cnt <= '0;
        note_idx <= note_idx + 3'd1;
      end else begin
        tick_cnt <= tick_cnt + 32'd1;
      end
    end
  end

  assign top_valid = ~top_sent;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      phase <= '0;
    end else begin
      phase <= phase + delta_q;
    end
  end

  always_comb begin
    sin_idx   = phase[31:24];
    q_addr    = sin_idx[6] ? (7'd64 - {1'b0, sin_idx[5:0]}) : {1'b0, sin_idx[5:0]};
    q_val     = QSIN[q_addr];
    sine_next = sin_idx[7] ? (9'd128 - {1'b0, q_val}) : (9'd128 + {1'b0, q_val});
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sine_q <= '0;
    end else begin
      sine_q <= sine_next;
    end
  end

  assign compare    = {2'b00, sine_q[8:2]};
  assign period_end = (pwm_cnt == active_top);

  // Shadows load freely; active values only change at the period boundary.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      shadow_top <= PWM_TOP;
      shadow_cmp <= '0;
      active_top <= PWM_TOP;
      active_cmp <= '0;
      pwm_cnt    <= '0;
      pwm_q      <= 1'b0;
    end else begin
      if (top_valid) begin
        shadow_top <= PWM_TOP;
      end
      shadow_cmp <= compare;
      pwm_q      <= ({1'b0, pwm_cnt} < active_cmp);
      if (period_end) begin
        pwm_cnt    <= '0;
        active_top <= shadow_top;
        active_cmp <= shadow_cmp;
      end else begin
        pwm_cnt <= pwm_cnt + 8'd1;
      end
    end
  end

  assign o_pwm        = pwm_q;
  assign o_pwm_n      = ~pwm_q;
  assign o_phase      = phase;
  assign o_phase_msb  = phase[31];
  assign o_cycle_end  = period_end;
  assign o_note_index = note_idx;

endmodule

// File: tb/tb_pwm_tone_engine.sv
// Scoreboard bench for pwm_tone_engine: a cycle-count based reference model
// queues expected outputs, a monitor compares them on the falling edge.
module tb_pwm_tone_engine;

  localparam int unsigned NT  = 4;
  localparam int unsigned TOP = 63;
  localparam real PI = 3.14159265358979;

  logic        i_clk;
  logic        i_rst;
  logic        o_pwm;
  logic        o_pwm_n;
  logic        o_phase_msb;
  logic        o_cycle_end;
  logic [2:0]  o_note_index;
  logic [31:0] o_phase;

  pwm_tone_engine #(
    .NOTE_TICKS(NT),
    .PWM_TOP(8'd63)
  ) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .o_pwm(o_pwm),
    .o_pwm_n(o_pwm_n),
    .o_phase_msb(o_phase_msb),
    .o_cycle_end(o_cycle_end),
    .o_note_index(o_note_index),
    .o_phase(o_phase)
  );

  typedef struct {
    logic [31:0] phase;
    logic [2:0]  idx;
    logic        pwm;
    logic        cyc;
  } exp_t;

  exp_t exp_q[$];
  event kick;
  int n_cmp = 0;
  int n_bad = 0;

  int unsigned notes [0:7] = '{44947, 50451, 56630, 59997, 67344, 75591, 84848, 89894};

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  function automatic int sine_ref(int i);
    real x;
    x = 128.0 + 128.0 * $sin(2.0 * PI * i / 256.0);
    return $rtoi(x + 0.5);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic exp_t reset_exp();
    exp_t e;
    e.phase = '0;
    e.idx   = '0;
    e.pwm   = 1'b0;
    e.cyc   = 1'b0;
    return e;
  endfunction

  // Reference model: n counts edges since reset release; note index, PWM
  // counter and period boundaries follow directly from n.
  initial begin
    int unsigned m_n;
    logic [31:0] m_phase;
    logic [31:0] m_delta;
    int          m_sine;
    int          m_csh;
    int          m_act;
    int unsigned cnt_old;
    int unsigned idx_old;
    bit          new_pwm;
    int          new_act;
    int          new_csh;
    int          new_sine;
    exp_t        e;
    forever begin
      @(posedge i_clk);
      if (i_rst) begin
        m_n = 0; m_phase = '0; m_delta = notes[0];
        m_sine = 0; m_csh = 0; m_act = 0;
        exp_q.push_back(reset_exp());
      end else begin
        cnt_old  = m_n % (TOP + 1);
        idx_old  = (m_n / NT) % 8;
        new_pwm  = (int'(cnt_old) < m_act);
        new_act  = (cnt_old == TOP) ? m_csh : m_act;
        new_csh  = m_sine / 4;
        new_sine = sine_ref(int'(m_phase[31:24]));
        m_phase  = m_phase + m_delta;
        m_delta  = notes[idx_old];
        m_sine   = new_sine;
        m_csh    = new_csh;
        m_act    = new_act;
        m_n      = m_n + 1;
        e.phase  = m_phase;
        e.idx    = 3'((m_n / NT) % 8);
        e.pwm    = new_pwm;
        e.cyc    = ((m_n % (TOP + 1)) == TOP);
        exp_q.push_back(e);
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge i_clk or kick);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("phase",     o_phase,                e.phase);
        chk("phase_msb", {31'd0, o_phase_msb},   {31'd0, e.phase[31]});
        chk("note_idx",  {29'd0, o_note_index},  {29'd0, e.idx});
        chk("pwm",       {31'd0, o_pwm},         {31'd0, e.pwm});
        chk("pwm_n",     {31'd0, o_pwm_n},       {31'd0, ~e.pwm});
        chk("cycle_end", {31'd0, o_cycle_end},   {31'd0, e.cyc});
      end
    end
  end

  initial begin
    i_rst = 1'b1;
    repeat (3) @(posedge i_clk);
    #3 i_rst = 1'b0;
    for (int s = 0; s < 6; s++) begin
      int unsigned len;
      len = $urandom_range(100, 1200);
      repeat (len) @(posedge i_clk);
      // Assert reset after the falling edge so the check sees only the async clear.
      #($urandom_range(6, 8));
      i_rst = 1'b1;
      #1;
      exp_q.push_back(reset_exp());
      ->kick;
      repeat ($urandom_range(1, 3)) @(posedge i_clk);
      #3 i_rst = 1'b0;
    end
    repeat (200) @(posedge i_clk);
    @(negedge i_clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
